// File: rtl/lsu_arbiter_if.sv
// Bus bundle between the two LSU requesters, the arbiter and the LSU.
// Port names keep their arbiter-side direction prefixes.
interface lsu_arbiter_if;
    logic        i_m0_req;
    logic [31:0] i_m0_addr;
    logic [31:0] i_m0_wdata;
    logic        i_m0_wren;
    logic [2:0]  i_m0_funct3;
    logic        o_m0_gnt;
    logic        o_m0_done;
    logic [31:0] o_m0_rdata;

    logic        i_m1_req;
    logic [31:0] i_m1_addr;
    logic [31:0] i_m1_wdata;
    logic        i_m1_wren;
    logic [2:0]  i_m1_funct3;
    logic        o_m1_gnt;
    logic        o_m1_done;
    logic [31:0] o_m1_rdata;

    logic [31:0] o_lsu_addr;
    logic [31:0] o_lsu_data;
    logic        o_lsu_wren;
    logic [2:0]  o_funct3;
    logic [31:0] i_ld_data;
    logic        o_busy;

    modport slave (
        input  i_m0_req, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_funct3,
        input  i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_funct3,
        input  i_ld_data,
        output o_m0_gnt, o_m0_done, o_m0_rdata,
        output o_m1_gnt, o_m1_done, o_m1_rdata,
        output o_lsu_addr, o_lsu_data, o_lsu_wren, o_funct3, o_busy
    );

    modport master (
        output i_m0_req, i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_funct3,
        output i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_funct3,
        output i_ld_data,
        input  o_m0_gnt, o_m0_done, o_m0_rdata,
        input  o_m1_gnt, o_m1_done, o_m1_rdata,
        input  o_lsu_addr, o_lsu_data, o_lsu_wren, o_funct3, o_busy
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing the LSU port between the CPU data port (0)
// and the debug/loader port (1); one access cycle, fixed load latency.
module lsu_arbiter #(
    parameter int LD_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    lsu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [1:0] CNT_INIT =
        (LD_LAT > 0) ? 2'(LD_LAT - 1) : 2'd0;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        last_gnt;
    logic        owner;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_wren;
    logic [2:0]  cmd_funct3;
    logic [31:0] rdata0, rdata1;
    logic        done0, done1;
    logic        arb_en, gnt0, gnt1, capture;

    // Reset gates the grants so every output is 0 while i_rst is low.
    always_comb begin
        arb_en = i_rst && (state == IDLE || state == DONE);
        gnt0   = arb_en && bus.i_m0_req && (!bus.i_m1_req || last_gnt);
        gnt1   = arb_en && bus.i_m1_req && (!bus.i_m0_req || !last_gnt);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_nxt = (gnt0 || gnt1) ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (cmd_wren) begin
                    state_nxt = DONE;
                end else if (LD_LAT == 0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_gnt   <= 1'b1;
            owner      <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_wren   <= 1'b0;
            cmd_funct3 <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done0 <= (state_nxt == DONE) && !owner;
            done1 <= (state_nxt == DONE) && owner;
            if (gnt0) begin
                cmd_addr   <= bus.i_m0_addr;
                cmd_wdata  <= bus.i_m0_wdata;
                cmd_wren   <= bus.i_m0_wren;
                cmd_funct3 <= bus.i_m0_funct3;
                owner      <= 1'b0;
                last_gnt   <= 1'b0;
            end else if (gnt1) begin
                cmd_addr   <= bus.i_m1_addr;
                cmd_wdata  <= bus.i_m1_wdata;
                cmd_wren   <= bus.i_m1_wren;
                cmd_funct3 <= bus.i_m1_funct3;
                owner      <= 1'b1;
                last_gnt   <= 1'b1;
            end
            if (capture && !owner) rdata0 <= bus.i_ld_data;
            if (capture && owner)  rdata1 <= bus.i_ld_data;
        end
    end

    assign bus.o_m0_gnt   = gnt0;
    assign bus.o_m1_gnt   = gnt1;
    assign bus.o_m0_done  = done0;
    assign bus.o_m1_done  = done1;
    assign bus.o_m0_rdata = rdata0;
    assign bus.o_m1_rdata = rdata1;
    assign bus.o_lsu_addr = cmd_addr;
    assign bus.o_lsu_data = cmd_wdata;
    assign bus.o_funct3   = cmd_funct3;
    assign bus.o_lsu_wren = (state == ACCESS) && cmd_wren;
    assign bus.o_busy     = (state != IDLE);
endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model with its own LSU memory.
module tb_lsu_arbiter;
    localparam int LAT = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [2:0]  f3;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_arbiter_if bus();

    lsu_arbiter #(.LD_LAT(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    bit          pend[2];
    cmd_t        pend_cmd[2];
    bit          cont[2];
    bit          rnd;

    bit          act;
    bit          own;
    bit          last;
    int          t_gnt, t_done;
    cmd_t        acmd;
    cmd_t        lsu_cmd;
    logic [31:0] ldval;
    logic [31:0] exp_rd[2];
    logic [31:0] mem [logic [31:0]];

    int cyc = 0;
    int ncmp = 0;
    int nerr = 0;

    function automatic logic [31:0] rd_mem(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic cmd_t rnd_cmd(bit load_only);
        cmd_t c;
        c.addr  = 32'h100 + 32'($urandom_range(0, 7) << 2);
        c.wdata = $urandom;
        c.wren  = load_only ? 1'b0 : 1'($urandom_range(0, 1));
        c.f3    = 3'($urandom_range(0, 7));
        return c;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        act       = 1'b0;
        last      = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        lsu_cmd   = '0;
    endtask

    // One clock: entered at posedge+1, drives, checks at negedge, commits.
    task automatic cycle();
        bit eg[2];
        bit ed[2];
        bit ewr;
        bit ebusy;
        int win;
        eg[0] = 0; eg[1] = 0; ed[0] = 0; ed[1] = 0;
        ewr = 0; ebusy = 0; win = -1;

        if (rnd) begin
            rst_n = ($urandom_range(0, 119) != 0);
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && $urandom_range(0, 19) == 0) begin
                    pend[p] = 0;
                end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]     = 1;
                    pend_cmd[p] = rnd_cmd(0);
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (cont[p] && !pend[p]) begin
                pend[p]     = 1;
                pend_cmd[p] = rnd_cmd(1);
            end
        end

        bus.i_m0_req    = pend[0];
        bus.i_m0_addr   = pend_cmd[0].addr;
        bus.i_m0_wdata  = pend_cmd[0].wdata;
        bus.i_m0_wren   = pend_cmd[0].wren;
        bus.i_m0_funct3 = pend_cmd[0].f3;
        bus.i_m1_req    = pend[1];
        bus.i_m1_addr   = pend_cmd[1].addr;
        bus.i_m1_wdata  = pend_cmd[1].wdata;
        bus.i_m1_wren   = pend_cmd[1].wren;
        bus.i_m1_funct3 = pend_cmd[1].f3;
        bus.i_ld_data   = $urandom;

        if (!rst_n) begin
            model_reset();
        end else begin
            if (act && cyc == t_gnt + 1) begin
                lsu_cmd = acmd;
                ewr     = acmd.wren;
                if (acmd.wren) mem[acmd.addr] = acmd.wdata;
            end
            if (act && !acmd.wren && cyc == t_gnt + 1 + LAT) begin
                ldval         = rd_mem(acmd.addr);
                bus.i_ld_data = ldval;
            end
            if (act && cyc == t_done) begin
                ed[own] = 1;
                if (!acmd.wren) exp_rd[own] = ldval;
            end
            ebusy = act && cyc > t_gnt;
            if (!act || cyc >= t_done) begin
                if (pend[0] && pend[1]) win = last ? 0 : 1;
                else if (pend[0])       win = 0;
                else if (pend[1])       win = 1;
                if (win >= 0) eg[win] = 1;
            end
        end

        #4;
        chk("gnt0",   bus.o_m0_gnt,   eg[0]);
        chk("gnt1",   bus.o_m1_gnt,   eg[1]);
        chk("done0",  bus.o_m0_done,  ed[0]);
        chk("done1",  bus.o_m1_done,  ed[1]);
        chk("rdata0", bus.o_m0_rdata, exp_rd[0]);
        chk("rdata1", bus.o_m1_rdata, exp_rd[1]);
        chk("busy",   bus.o_busy,     ebusy);
        chk("wren",   bus.o_lsu_wren, ewr);
        chk("addr",   bus.o_lsu_addr, lsu_cmd.addr);
        chk("data",   bus.o_lsu_data, lsu_cmd.wdata);
        chk("funct3", bus.o_funct3,   32'(lsu_cmd.f3));

        if (win >= 0) begin
            act     = 1;
            own     = win[0];
            acmd    = pend_cmd[win];
            t_gnt   = cyc;
            t_done  = cyc + 2 + (acmd.wren ? 0 : LAT);
            last    = win[0];
            pend[win] = 0;
        end else if (act && cyc >= t_done) begin
            act = 0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rnd = 0;
        pend[0] = 0; pend[1] = 0;
        cont[0] = 0; cont[1] = 0;
        pend_cmd[0] = '0; pend_cmd[1] = '0;
        ldval = '0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) cycle();
        rst_n = 1;

        pend[0]     = 1;
        pend_cmd[0] = '{addr: 32'h10, wdata: 32'hDEAD_BEEF,
                        wren: 1'b1, f3: 3'b010};
        repeat (4) cycle();

        pend[0]     = 1;
        pend_cmd[0] = '{addr: 32'h10, wdata: 32'h0,
                        wren: 1'b0, f3: 3'b010};
        repeat (5) cycle();
        chk("load_rdata0", bus.o_m0_rdata, 32'hDEAD_BEEF);
        chk("load_rdata1", bus.o_m1_rdata, 32'h0);

        pend[0]     = 1;
        pend_cmd[0] = '{addr: 32'h40, wdata: 32'h0,
                        wren: 1'b0, f3: 3'b010};
        repeat (2) cycle();
        pend[1]     = 1;
        pend_cmd[1] = '{addr: 32'h200, wdata: 32'h0000_00FF,
                        wren: 1'b1, f3: 3'b010};
        repeat (6) cycle();

        rst_n   = 0;
        cont[0] = 1;
        cont[1] = 1;
        cycle();
        rst_n = 1;
        repeat (14) cycle();
        cont[0] = 0;
        cont[1] = 0;
        repeat (10) cycle();

        pend[1]     = 1;
        pend_cmd[1] = '{addr: 32'h200, wdata: 32'h0,
                        wren: 1'b0, f3: 3'b100};
        repeat (2) cycle();
        pend[0]     = 1;
        pend_cmd[0] = rnd_cmd(1);
        pend[1]     = 1;
        pend_cmd[1] = rnd_cmd(1);
        rst_n = 0;
        repeat (2) cycle();
        rst_n = 1;
        repeat (8) cycle();

        rnd = 1;
        repeat (600) cycle();
        rnd   = 0;
        rst_n = 1;
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Shares the single LSU load/store port between two requesters: port 0 is the CPU pipeline data port, port 1 is the debug/program-loader port.
- Arbitrates round-robin and registers the winning command. It drives the LSU for exactly one access cycle, waits a fixed load latency, then returns a registered completion and load data to the winner.
- Sits between the core/loader and the LSU; the LSU address decode (data RAM vs IO) is unchanged.

Parameters:
- LD_LAT, 1, cycles from the LSU access cycle to the cycle in which i_ld_data is valid (0 = combinational read, max 3).

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  asynchronous active-low reset
- i_m0_req / i_m1_req  input  1  access request; held with command stable until grant
- i_m0_addr / i_m1_addr  input  32  byte address
- i_m0_wdata / i_m1_wdata  input  32  store data
- i_m0_wren / i_m1_wren  input  1  1 = store, 0 = load
- i_m0_funct3 / i_m1_funct3  input  3  access size/sign code, passed through unchanged
- o_m0_gnt / o_m1_gnt  output  1  combinational accept pulse; command sampled this cycle
- o_m0_done / o_m1_done  output  1  registered one-cycle completion pulse
- o_m0_rdata / o_m1_rdata  output  32  load data, valid with done for loads
- o_lsu_addr  output  32  to LSU i_lsu_addr
- o_lsu_data  output  32  to LSU i_lsu_data
- o_lsu_wren  output  1  to LSU i_lsu_wren
- o_funct3  output  3  to LSU funct3
- i_ld_data  input  32  from LSU o_ld_data
- o_busy  output  1  1 when state != IDLE

Behaviour:
- Reset (i_rst=0, async):
  - State IDLE; last_gnt = 1, so port 0 wins the first tie.
  - All outputs 0; command and rdata registers 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Grant is combinational from the reqs. Single req wins; both reqs: the winner is the port != last_gnt.
  - Grant cycle T: o_mX_gnt=1. On the edge, register {addr, wdata, wren, funct3, owner} and update last_gnt. Next state is ACCESS.
  - No req: stay in IDLE.
- ACCESS (T+1):
  - o_lsu_addr/o_lsu_data/o_funct3 are driven from the command registers; o_lsu_wren = cmd_wren, in this state only.
  - Store: go to DONE.
  - Load, LD_LAT=0: capture i_ld_data this cycle, go to DONE.
  - Load, LD_LAT>0: go to WAIT with counter = LD_LAT-1.
- WAIT:
  - o_lsu_wren=0; address and funct3 are held.
  - Counter decrements each cycle. At 0, capture i_ld_data into the owner's rdata register and go to DONE.
- DONE:
  - o_mX_done=1 for the owner only.
  - o_mX_rdata holds the captured data, and keeps it until the next load completion for that port; it is unchanged by stores.
  - Arbitration runs this cycle exactly as in IDLE: a grant here goes directly to ACCESS, else to IDLE.
- Timing:
  - Store latency: gnt at T, done at T+2.
  - Load latency: gnt at T, done at T+2+LD_LAT.
  - Back-to-back throughput is one access per 2+LD_LAT cycles.
- o_lsu_wren is never high outside ACCESS. The outputs to the LSU keep the last command outside ACCESS/WAIT.
- Simultaneous events:
  - A requester's req and its own done in the same cycle is legal; it is granted normally.
  - The non-owner's req during ACCESS/WAIT is not granted and must stay held.
- Req deassert before grant: the request is withdrawn, with no side effects.
- Reset mid-operation: the FSM aborts immediately and no done is issued. A store whose ACCESS edge already occurred has completed in the LSU; a store not yet in ACCESS is dropped.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1; neither port waits more than one foreign access.

Test Plan:
- Reset, then M0 store addr=0x0000_0010, wdata=0xDEAD_BEEF, funct3=3'b010 -> gnt0 at T; o_lsu_wren=1 with addr 0x10 at T+1 only; done0 at T+2; o_busy=0 at T+3 if idle.
- M0 load addr 0x10, LD_LAT=1, model returns 0xDEAD_BEEF -> done0 at T+3 with o_m0_rdata=0xDEAD_BEEF; o_m1_rdata unchanged (0).
- Both reqs asserted from reset, continuous loads -> grants 0,1,0,1, spaced every 3 cycles; the first grant is to port 0; each done goes to the correct port with its own data.
- M1 store addr 0x0000_0200 (IO region), wdata 0x0000_00FF, issued while M0 load in WAIT -> M1 not granted until M0's DONE cycle; gnt1 coincides with done0.
- Assert i_rst=0 during WAIT of an M1 load -> all outputs 0 asynchronously, no done1; after release, the first tie goes to port 0.
- LD_LAT=0 build, M0 load -> done0 at T+2 with data equal to i_ld_data sampled in the ACCESS cycle; LD_LAT=3 build -> done0 at T+5.
